ram_dp_sr_sw_be: RTL
====================

RAM_DP_SR_SW_BE -- requirements
Module: ram_dp_sr_sw_be

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning address width; RAM_DEPTH = 1 << ADDR_WIDTH.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, meaning the read pipeline depth; legal values are 1 or 2.
REQ-004 The block SHALL have parameter RDW_MODE, default 0, meaning same-address read/write behaviour: 0 = read-old, 1 = write-first.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-009 The block SHALL have port wr_addr, input, ADDR_WIDTH bits: write address.
REQ-010 The block SHALL have port wr_be, input, DATA_WIDTH/8 bits: byte-lane write enables.
REQ-011 The block SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-013 The block SHALL have port rd_addr, input, ADDR_WIDTH bits: read address.
REQ-014 The block SHALL have port rd_data, output, DATA_WIDTH bits: registered read data.
REQ-015 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking rd_data valid.
REQ-016 The block SHALL have port init_busy, output, 1 bit: high while the clear sweep runs.

Function
REQ-017 The FSM SHALL have two states, INIT and READY; reset forces INIT with the sweep counter at 0.
REQ-018 In INIT, each clock SHALL write all-zero to mem[counter] and increment the counter.
REQ-019 INIT SHALL transition to READY on the edge that writes address RAM_DEPTH-1; the counter wraps to 0 and no further sweep writes occur.
REQ-020 In INIT, wr_en and rd_en SHALL be ignored: no user write, no rd_valid.
REQ-021 In READY, a wr_en edge SHALL update only those byte lanes of mem[wr_addr] whose wr_be bit is 1; wr_be = 0 changes nothing.
REQ-022 In READY, a read accepted at edge N SHALL drive rd_data and pulse rd_valid after edge N+RD_LATENCY-1 (latency 1: visible the cycle after the request).
REQ-023 Back-to-back reads SHALL be accepted every cycle, giving one rd_valid pulse per request, in order.
REQ-024 When rd_valid = 0, rd_data SHALL hold its last value.
REQ-025 For a same-cycle read and write to the same address with RDW_MODE = 0, the read SHALL return the pre-write word.
REQ-026 For a same-cycle read and write to the same address with RDW_MODE = 1, the read SHALL return the byte-merged post-write word.
REQ-027 Reads and writes to different addresses in the same cycle SHALL be independent.

Reset
REQ-028 While reset = 1: rd_data = 0, rd_valid = 0, init_busy = 1, state = INIT, counter = 0, read pipeline flushed, and no memory writes.
REQ-029 After reset is sampled low at edge R, sweep writes SHALL occur on edges R+1 through R+RAM_DEPTH, and init_busy SHALL be low after edge R+RAM_DEPTH.
REQ-030 Reset asserted mid-sweep or mid-read SHALL restart the sweep at address 0 and discard in-flight reads, with no rd_valid emitted for them.

Structure
REQ-031 Package ram_pkg SHALL hold the state enum (INIT, READY) and the RDW_MODE encodings.
REQ-032 Sub-module ram_sdp_core SHALL hold the array, the byte-enable write and the first read register; the top holds the FSM, bypass mux and optional second pipeline stage.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4)
REQ-033 Sweep: release reset, then read addresses 0..15 once init_busy is low -> all read 0x00000000, and init_busy is low exactly 16 cycles after release.
REQ-034 Byte enables: write 0xAABBCCDD with be=4'hF, then 0x11223344 with be=4'b0101, to address 3, then read -> 0xAA22CC44.
REQ-035 Collision: address 5 holds 0x1; same-cycle write 0x2 and read of address 5 -> RDW_MODE=0 returns 0x1, RDW_MODE=1 returns 0x2.
REQ-036 Latency: RD_LATENCY=2 with reads to addresses 1, 2, 3 on consecutive cycles -> rd_valid high on cycles +2, +3, +4 with matching data.
REQ-037 Mid-sweep reset: assert reset at sweep address 7 after writing data -> sweep restarts, all 16 words read 0, and no spurious rd_valid.
REQ-038 INIT blocking: wr_en and rd_en asserted during the sweep -> no rd_valid, and the memory still reads all-zero afterward.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types for the byte-enable RAM: controller state and read-during-write encodings.
// Imported by the top; the storage core is type-agnostic.
package ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int RDW_READ_OLD    = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_sdp_core.sv
// Simple dual-port storage with byte-lane writes and a single registered read port.
// One-cycle read latency; the read register holds when re is low and has no backpressure.
module ram_sdp_core #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we && wbe[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Non-blocking read sees the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_dp_sr_sw_be.sv
// Byte-enable dual-port RAM that zero-fills itself after reset, then serves reads and writes.
// Read latency RD_LATENCY (1 or 2) cycles; requests during the clear sweep are dropped, no backpressure.
module ram_dp_sr_sw_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  ram_state_t              state;
  logic [ADDR_WIDTH-1:0]   sweep_cnt;
  logic                    init_busy_q;

  logic                    wr_acc;
  logic                    rd_acc;
  logic                    core_we;
  logic [ADDR_WIDTH-1:0]   core_waddr;
  logic [NUM_BYTES-1:0]    core_wbe;
  logic [DATA_WIDTH-1:0]   core_wdata;
  logic [DATA_WIDTH-1:0]   core_rdata;

  logic                    s1_vld_q;
  logic                    fwd_vld_q;
  logic [NUM_BYTES-1:0]    fwd_be_q;
  logic [DATA_WIDTH-1:0]   fwd_dat_q;
  logic [DATA_WIDTH-1:0]   s1_dat;

  assign wr_acc = (state == READY) && wr_en;
  assign rd_acc = (state == READY) && rd_en;

  // The sweep owns the write port while clearing; reset blocks every write.
  assign core_we    = !reset && ((state == INIT) || wr_acc);
  assign core_waddr = (state == INIT) ? sweep_cnt : wr_addr;
  assign core_wbe   = (state == INIT) ? '1 : wr_be;
  assign core_wdata = (state == INIT) ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      sweep_cnt   <= '0;
      init_busy_q <= 1'b1;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == '1) begin
        state       <= READY;
        init_busy_q <= 1'b0;
      end
    end
  end

  assign init_busy = init_busy_q;

  ram_sdp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .we    (core_we),
    .waddr (core_waddr),
    .wbe   (core_wbe),
    .wdata (core_wdata),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (core_rdata)
  );

  // Capture the colliding write so write-first mode can patch the old word lane by lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      fwd_vld_q <= 1'b0;
      fwd_be_q  <= '0;
      fwd_dat_q <= '0;
    end else begin
      s1_vld_q <= rd_acc;
      if (rd_acc) begin
        fwd_vld_q <= (RDW_MODE == RDW_WRITE_FIRST) && wr_acc && (wr_addr == rd_addr);
        fwd_be_q  <= wr_be;
        fwd_dat_q <= wr_data;
      end
    end
  end

  always_comb begin
    s1_dat = core_rdata;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (fwd_vld_q && fwd_be_q[i]) begin
        s1_dat[i*8 +: 8] = fwd_dat_q[i*8 +: 8];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_vld_q;
      logic [DATA_WIDTH-1:0] s2_dat_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) begin
            s2_dat_q <= s1_dat;
          end
        end
      end

      assign rd_data  = s2_dat_q;
      assign rd_valid = s2_vld_q;
    end else begin : g_lat1
      assign rd_data  = s1_dat;
      assign rd_valid = s1_vld_q;
    end
  endgenerate

endmodule
